// File: rtl/arm_pkg.sv
// Shared ARM definitions: condition-field encodings and {N,Z,C,V} flag bit positions.
// The ALU uses the same package, so flag ordering stays consistent between the two blocks.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition decoder: reports whether cond passes for the given flags.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// ARM execute-stage condition unit: gates decoder controls by the condition check and
// owns the {N,Z,C,V} flag register plus a saturating count of committed flag updates.
module cond_unit
    import arm_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic       stall,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs_in,
    input  logic       reg_w_in,
    input  logic       mem_w_in,
    output logic       pcs_out,
    output logic       reg_w_out,
    output logic       mem_w_out,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic [7:0] flag_upd_cnt
);

    logic [3:0] flag_q;
    logic [7:0] cnt_q;
    logic       pass;
    logic       commit;

    // Condition is judged on the registered flags, so the instruction never sees its own ALU result.
    cond_check u_cond_check (
        .cond  (cond),
        .flags (flag_q),
        .pass  (pass)
    );

    assign cond_ex   = valid_in & pass;
    assign commit    = cond_ex & ~stall;
    assign pcs_out   = pcs_in   & commit;
    assign reg_w_out = reg_w_in & commit;
    assign mem_w_out = mem_w_in & commit;

    assign flags        = flag_q;
    assign flag_upd_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= RESET_FLAGS;
            cnt_q  <= 8'd0;
        end else if (commit) begin
            if (flag_w[1]) begin
                flag_q[FLAG_N] <= alu_flags[FLAG_N];
                flag_q[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[0]) begin
                flag_q[FLAG_C] <= alu_flags[FLAG_C];
                flag_q[FLAG_V] <= alu_flags[FLAG_V];
            end
            if ((|flag_w) && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a reference flag/counter model pushes expected outputs
// to a queue as each cycle is driven; they are popped and compared before the next clock edge.
module tb_cond_unit;

    typedef struct {
        logic       cex;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [3:0] flags;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in, stall;
    logic [3:0] cond, alu_flags;
    logic [1:0] flag_w;
    logic       pcs_in, reg_w_in, mem_w_in;
    logic       pcs_out, reg_w_out, mem_w_out, cond_ex;
    logic [3:0] flags;
    logic [7:0] flag_upd_cnt;

    exp_t       expQ[$];
    logic [3:0] modelFlags;
    logic [7:0] modelCnt;
    int         numCompared   = 0;
    int         numMismatched = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .stall        (stall),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_w       (flag_w),
        .pcs_in       (pcs_in),
        .reg_w_in     (reg_w_in),
        .mem_w_in     (mem_w_in),
        .pcs_out      (pcs_out),
        .reg_w_out    (reg_w_out),
        .mem_w_out    (mem_w_out),
        .cond_ex      (cond_ex),
        .flags        (flags),
        .flag_upd_cnt (flag_upd_cnt)
    );

    // Reference condition written in the ARM "base test on cond[3:1], invert on cond[0]" form.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareOutputs(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, "_cond_ex"},   {31'd0, cond_ex},   {31'd0, e.cex});
        checkOutput({tag, "_pcs_out"},   {31'd0, pcs_out},   {31'd0, e.pcs});
        checkOutput({tag, "_reg_w_out"}, {31'd0, reg_w_out}, {31'd0, e.regw});
        checkOutput({tag, "_mem_w_out"}, {31'd0, mem_w_out}, {31'd0, e.memw});
        checkOutput({tag, "_flags"},     {28'd0, flags},     {28'd0, e.flags});
        checkOutput({tag, "_cnt"},       {24'd0, flag_upd_cnt}, {24'd0, e.cnt});
    endtask

    // Drive one cycle, predict, compare mid-cycle, then advance the model across the clock edge.
    task automatic applyStimulus(input string tag, input logic v, input logic st, input logic [3:0] c,
                                 input logic [3:0] alu, input logic [1:0] fw,
                                 input logic p, input logic rw, input logic mw);
        exp_t e;
        logic commit;
        valid_in = v; stall = st; cond = c; alu_flags = alu; flag_w = fw;
        pcs_in = p; reg_w_in = rw; mem_w_in = mw;
        e.cex   = v && refCond(c, modelFlags);
        commit  = e.cex && !st;
        e.pcs   = p && commit;
        e.regw  = rw && commit;
        e.memw  = mw && commit;
        e.flags = modelFlags;
        e.cnt   = modelCnt;
        expQ.push_back(e);
        #2;
        compareOutputs(tag);
        @(posedge clk);
        if (rst_n && commit) begin
            if (fw[1]) modelFlags[3:2] = alu[3:2];
            if (fw[0]) modelFlags[1:0] = alu[1:0];
            if (fw != 2'b00 && modelCnt != 8'hFF) modelCnt = modelCnt + 8'd1;
        end
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelFlags = 4'b0000;
        modelCnt   = 8'd0;
        #1;
        applyStimulus("reset", 1'b1, 1'b0, 4'b0000, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        valid_in = 0; stall = 0; cond = 0; alu_flags = 0; flag_w = 0;
        pcs_in = 0; reg_w_in = 0; mem_w_in = 0;
        modelFlags = 4'b0000;
        modelCnt   = 8'd0;
        #1;
        doReset();

        applyStimulus("post_reset_eq", 1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);

        // Pre-update semantics: EQ fails on Z=0 even though the ALU reports Z=1.
        applyStimulus("pre_update", 1'b1, 1'b0, 4'b0000, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0);

        // Dependent back-to-back: AL sets Z, following EQ passes with no bubble.
        applyStimulus("dep_al",  1'b1, 1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus("dep_eq",  1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);

        // Split write from 1111.
        applyStimulus("split_set", 1'b1, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus("split_cv",  1'b1, 1'b0, 4'b1110, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus("split_nz",  1'b1, 1'b0, 4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus("split_end", 1'b0, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);

        // Stall holds outputs low and flags frozen until released.
        for (int i = 0; i < 3; i++)
            applyStimulus("stall_on", 1'b1, 1'b1, 4'b1110, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1);
        applyStimulus("stall_off", 1'b1, 1'b0, 4'b1110, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1);
        applyStimulus("stall_chk", 1'b0, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Full condition table sweep: load each flag value, then test every code against it.
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                applyStimulus("sweep_load", 1'b1, 1'b0, 4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0);
                applyStimulus("sweep_cond", 1'b1, 1'b0, 4'(c), 4'(~f), 2'b00, 1'b1, 1'b1, 1'b1);
            end
        end

        // Saturation from a clean counter.
        doReset();
        for (int i = 0; i < 300; i++)
            applyStimulus("saturate", 1'b1, 1'b0, 4'b1110, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3)),
                          1'b0, 1'b0, 1'b0);
        applyStimulus("sat_final", 1'b0, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_value", {24'd0, flag_upd_cnt}, 32'h0000_00FF);

        // Asynchronous reset mid-instruction: takes effect without a clock edge and drops the update.
        valid_in = 1'b1; stall = 1'b0; cond = 4'b1110; alu_flags = 4'b1111; flag_w = 2'b11;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_flags", {28'd0, flags}, 32'd0);
        checkOutput("async_cnt", {24'd0, flag_upd_cnt}, 32'd0);
        modelFlags = 4'b0000;
        modelCnt   = 8'd0;
        applyStimulus("in_reset", 1'b1, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus("resume_set", 1'b1, 1'b0, 4'b1110, 4'b1010, 2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus("resume_chk", 1'b1, 1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 4'b0000, the reset value of the {N,Z,C,V} flag register.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  an instruction is present in execute this cycle.
REQ-005 SHALL have port stall  input  1  execute is held; no state update this cycle.
REQ-006 SHALL have port cond  input  4  ARM condition field, instr[31:28].
REQ-007 SHALL have port alu_flags  input  4  {negative, zero, carry, overflow} from the ALU for the current instruction.
REQ-008 SHALL have port flag_w  input  2  flag-write request; bit1 updates N,Z, bit0 updates C,V.
REQ-009 SHALL have ports pcs_in, reg_w_in, mem_w_in  input  1 each  ungated decoder controls.
REQ-010 SHALL have ports pcs_out, reg_w_out, mem_w_out  output  1 each  gated controls.
REQ-011 SHALL have port cond_ex  output  1  the condition passes for the current instruction.
REQ-012 SHALL have port flags  output  4  current flag register {N,Z,C,V}.
REQ-013 SHALL have port flag_upd_cnt  output  8  count of committed flag updates; saturates at 8'hFF.

Function
REQ-014 SHALL evaluate cond combinationally against the registered flags only (pre-update values), never against alu_flags.
REQ-015 SHALL decode cond as follows:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 0
REQ-016 SHALL drive cond_ex = valid_in & decoded condition.
REQ-017 SHALL drive each *_out = *_in & cond_ex & ~stall, with zero latency.
REQ-018 SHALL define commit = valid_in & cond_ex & ~stall.
REQ-019 SHALL on a clock edge with commit & flag_w[1] load N,Z from alu_flags[3:2].
REQ-020 SHALL on a clock edge with commit & flag_w[0] load C,V from alu_flags[1:0].
REQ-021 SHALL otherwise hold each flag pair unchanged, including when stall=1, valid_in=0, or the condition fails.
REQ-022 SHALL increment flag_upd_cnt by 1 on each edge with commit & (|flag_w), holding at 8'hFF with no wrap.
REQ-023 SHALL make an update committed at edge k visible on flags, and used by the condition evaluation, from cycle k+1 onward; back-to-back dependent instructions need no bubble.
REQ-024 SHALL treat flag_w=2'b11 with a failing condition as no update.

Reset
REQ-025 SHALL on rst_n=0 immediately set flags=RESET_FLAGS and flag_upd_cnt=0, independent of clk.
REQ-026 SHALL while in reset present *_out from the combinational rule using RESET_FLAGS; a reset mid-instruction discards any pending update.
REQ-027 SHALL resume updates on the first rising clk edge after rst_n deasserts.

Structure
REQ-028 SHALL take the cond encodings (16 localparams) and the flag bit indices N=3, Z=2, C=1, V=0 from the shared package arm_pkg, which the ALU also uses.
REQ-029 SHALL contain one sub-module, cond_check, a purely combinational cond+flags->pass decoder; the flag register and counter reside in cond_unit.

Verification
REQ-030 SHALL cover reset: rst_n=0 then 1, with cond=0000 and valid_in=1 -> flags=0000, cond_ex=0, all *_out=0.
REQ-031 SHALL cover dependent update: cycle 0 AL, flag_w=11, alu_flags=0100; cycle 1 cond=0000 (EQ), reg_w_in=1 -> flags=0100 at cycle 1, cond_ex=1, reg_w_out=1, flag_upd_cnt=1.
REQ-032 SHALL cover pre-update semantics: flags=0000, cond=0000, flag_w=11, alu_flags=0100 -> cond_ex=0, flags stay 0000, counter unchanged.
REQ-033 SHALL cover split write: flags=1111, AL, flag_w=01, alu_flags=0000 -> flags=1100; then flag_w=10, alu_flags=0000 -> flags=0000.
REQ-034 SHALL cover stall: AL, flag_w=11, alu_flags=1001, stall=1 for 3 cycles -> *_out=0, flags unchanged; on stall=0 one update, counter +1.
REQ-035 SHALL cover the full cond table and saturation: sweep all 16 codes x 16 flag values against the REQ-015 table; 300 committed updates -> flag_upd_cnt=8'hFF.
